// File: rtl/vline_filter.sv
// Vertical line filter: two line buffers plus current pixel feed a per-channel
// bypass / line-repeat / avg2 / [1,2,1]/4 kernel, two-clock latency.
module vline_filter #(
    parameter int CH_W     = 8,
    parameter int CH       = 2,
    parameter int LINE_LEN = 640
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iSOF,
    input  logic                 iDVAL,
    input  logic [CH*CH_W-1:0]   iDATA,
    input  logic [1:0]           iMODE,
    output logic                 oDVAL,
    output logic [CH*CH_W-1:0]   oDATA,
    output logic                 oLINES_RDY
);

    localparam int W  = CH * CH_W;
    localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [CW-1:0]   COL_LAST = CW'(LINE_LEN - 1);
    localparam logic [CH_W+1:0] ONE      = (CH_W+2)'(1);
    localparam logic [CH_W+1:0] TWO      = (CH_W+2)'(2);

    logic [W-1:0]    r_lb1 [LINE_LEN];
    logic [W-1:0]    r_lb2 [LINE_LEN];

    logic [CW-1:0]   r_col;
    logic [1:0]      r_line_cnt;
    logic [1:0]      r_mode_q;
    logic            r_lines_rdy;

    logic            r_s1_vld;
    logic [1:0]      r_s1_mode;
    logic [1:0]      r_s1_line;
    logic [W-1:0]    r_s1_x0;
    logic [W-1:0]    r_s1_x1;
    logic [W-1:0]    r_s1_x2;

    logic [CW-1:0]   w_col;
    logic [1:0]      w_line;
    logic [CW-1:0]   w_col_nxt;
    logic [1:0]      w_line_nxt;
    logic [1:0]      w_mode;
    logic [W-1:0]    w_filt;
    logic [CH_W+1:0] w_a;
    logic [CH_W+1:0] w_b;
    logic [CH_W+1:0] w_c;
    logic [CH_W+1:0] w_r;

    // SOF restarts the frame for the pixel presented in the same cycle
    always_comb begin
        w_col      = iSOF ? '0 : r_col;
        w_line     = iSOF ? '0 : r_line_cnt;
        w_col_nxt  = w_col;
        w_line_nxt = w_line;
        w_mode     = r_mode_q;
        if (iDVAL) begin
            if (w_col == '0)
                w_mode = iMODE;
            if (w_col == COL_LAST) begin
                w_col_nxt = '0;
                if (w_line != 2'd2)
                    w_line_nxt = w_line + 2'd1;
            end else begin
                w_col_nxt = w_col + CW'(1);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_col       <= '0;
            r_line_cnt  <= '0;
            r_mode_q    <= '0;
            r_lines_rdy <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s1_mode   <= '0;
            r_s1_line   <= '0;
            oDVAL       <= 1'b0;
            oDATA       <= '0;
        end else begin
            r_col       <= w_col_nxt;
            r_line_cnt  <= w_line_nxt;
            r_mode_q    <= w_mode;
            r_lines_rdy <= (w_line_nxt == 2'd2);
            r_s1_vld    <= iDVAL;
            r_s1_mode   <= w_mode;
            r_s1_line   <= w_line;
            oDVAL       <= r_s1_vld;
            if (r_s1_vld)
                oDATA <= w_filt;
        end
    end

    // Line RAMs: read-before-write shifts LB1 into LB2 at the same column
    always_ff @(posedge iCLK) begin
        if (iDVAL && iRST_N) begin
            r_s1_x0      <= iDATA;
            r_s1_x1      <= r_lb1[w_col];
            r_s1_x2      <= r_lb2[w_col];
            r_lb2[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= iDATA;
        end
    end

    always_comb begin
        w_filt = '0;
        w_a    = '0;
        w_b    = '0;
        w_c    = '0;
        w_r    = '0;
        for (int i = 0; i < CH; i++) begin
            w_a = {2'b00, r_s1_x0[i*CH_W +: CH_W]};
            w_b = (r_s1_line == 2'd0) ? w_a
                                      : {2'b00, r_s1_x1[i*CH_W +: CH_W]};
            w_c = (r_s1_line == 2'd2) ? {2'b00, r_s1_x2[i*CH_W +: CH_W]}
                                      : w_b;
            unique case (r_s1_mode)
                2'd0: w_r = w_a;
                2'd1: w_r = w_b;
                2'd2: w_r = (w_a + w_b + ONE) >> 1;
                2'd3: w_r = (w_c + (w_b << 1) + w_a + TWO) >> 2;
            endcase
            w_filt[i*CH_W +: CH_W] = w_r[CH_W-1:0];
        end
    end

    assign oLINES_RDY = r_lines_rdy;

endmodule

// File: tb/tb_vline_filter.sv
// Bench for vline_filter: directed scenarios then random traffic against a
// frame-indexed reference model.
module tb_vline_filter;

    localparam int CH_W = 8;
    localparam int CH   = 2;
    localparam int LEN  = 4;
    localparam int W    = CH * CH_W;

    logic         iCLK = 1'b0;
    logic         iRST_N;
    logic         iSOF;
    logic         iDVAL;
    logic [W-1:0] iDATA;
    logic [1:0]   iMODE;
    logic         oDVAL;
    logic [W-1:0] oDATA;
    logic         oLINES_RDY;

    always #5 iCLK = ~iCLK;

    vline_filter #(.CH_W(CH_W), .CH(CH), .LINE_LEN(LEN)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iSOF       (iSOF),
        .iDVAL      (iDVAL),
        .iDATA      (iDATA),
        .iMODE      (iMODE),
        .oDVAL      (oDVAL),
        .oDATA      (oDATA),
        .oLINES_RDY (oLINES_RDY)
    );

    int checks = 0;
    int errors = 0;

    // Whole frame stored by absolute (line, col); model state
    logic [W-1:0] fr [int];
    int           m_col  = 0;
    int           m_line = 0;
    logic [1:0]   m_mode = 2'd0;
    logic         p_dval = 1'b0;
    logic [W-1:0] p_data = '0;
    logic [W-1:0] hold   = '0;

    function automatic logic [W-1:0] ref_px(input logic [W-1:0] x0,
                                            input int line, input int col,
                                            input logic [1:0] md);
        logic [W-1:0] a1;
        logic [W-1:0] a2;
        logic [W-1:0] r;
        int v0, v1, v2, o;
        a1 = (line >= 1) ? fr[(line-1)*LEN + col] : x0;
        a2 = (line >= 2) ? fr[(line-2)*LEN + col] : a1;
        r  = '0;
        for (int c = 0; c < CH; c++) begin
            v0 = int'(x0[c*CH_W +: CH_W]);
            v1 = int'(a1[c*CH_W +: CH_W]);
            v2 = int'(a2[c*CH_W +: CH_W]);
            case (md)
                2'd0:    o = v0;
                2'd1:    o = v1;
                2'd2:    o = (v0 + v1 + 1) / 2;
                default: o = (v2 + 2*v1 + v0 + 2) / 4;
            endcase
            r[c*CH_W +: CH_W] = CH_W'(o);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic sof, input logic dval,
                        input logic [W-1:0] d, input logic [1:0] md,
                        input string tag);
        iRST_N = rst_n;
        iSOF   = sof;
        iDVAL  = dval;
        iDATA  = d;
        iMODE  = md;
        @(posedge iCLK);
        #1;
        if (!rst_n) begin
            m_col  = 0;
            m_line = 0;
            m_mode = 2'd0;
            p_dval = 1'b0;
            hold   = '0;
            chk({tag, ".rst_dval"}, W'(oDVAL), '0);
            chk({tag, ".rst_data"}, oDATA, '0);
            chk({tag, ".rst_rdy"},  W'(oLINES_RDY), '0);
        end else begin
            chk({tag, ".dval"}, W'(oDVAL), W'(p_dval));
            if (p_dval) begin
                chk({tag, ".data"}, oDATA, p_data);
                hold = p_data;
            end else begin
                chk({tag, ".hold"}, oDATA, hold);
            end
            if (sof) begin
                m_col  = 0;
                m_line = 0;
            end
            if (dval) begin
                if (m_col == 0)
                    m_mode = md;
                p_data = ref_px(d, m_line, m_col, m_mode);
                fr[m_line*LEN + m_col] = d;
                m_col++;
                if (m_col == LEN) begin
                    m_col = 0;
                    m_line++;
                end
            end
            p_dval = dval;
            chk({tag, ".rdy"}, W'(oLINES_RDY), W'(m_line >= 2));
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b0, W'($urandom), 2'd0, tag);
    endtask

    initial begin
        logic [7:0]   v;
        logic         dv;
        int           n;
        logic [W-1:0] last_px;

        step(1'b0, 1'b0, 1'b0, '0, 2'd0, "rst");
        step(1'b0, 1'b0, 1'b0, '0, 2'd0, "rst");

        // constant lines 0,100,200 in filt3 -> 0, 25, 100
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < LEN; c++) begin
                v = 8'(l * 100);
                step(1'b1, (l == 0 && c == 0), 1'b1, {CH{v}}, 2'd3, "t2");
            end
        idle(2, "t2f");
        chk("t2.last", oDATA, {CH{8'd100}});

        // full-scale filt3, avg2 255/254, bypass
        for (int p = 0; p < 3*LEN; p++)
            step(1'b1, (p == 0), 1'b1, {CH{8'hff}}, 2'd3, "t3a");
        for (int p = 0; p < 2*LEN; p++)
            step(1'b1, (p == 0), 1'b1,
                 (p < LEN) ? {CH{8'hff}} : {CH{8'hfe}}, 2'd2, "t3b");
        for (int p = 0; p < 2*LEN; p++)
            step(1'b1, (p == 0), 1'b1, W'($urandom), 2'd0, "t3c");
        idle(2, "t3f");

        // 8 pixels with random gaps
        n = 0;
        step(1'b1, 1'b1, 1'b0, '0, 2'd1, "t4");
        while (n < 8) begin
            dv = 1'($urandom_range(0, 1));
            step(1'b1, 1'b0, dv, W'($urandom), 2'd1, "t4");
            if (dv) n++;
        end
        chk("t4.rdy_set", W'(oLINES_RDY), W'(1));
        idle(3, "t4f");

        // mode change mid-line is deferred to the next line
        for (int p = 0; p < 2*LEN; p++)
            step(1'b1, (p == 0), 1'b1, W'($urandom),
                 (p < 2) ? 2'd0 : 2'd3, "t5");
        idle(2, "t5f");

        // SOF at col2 of line 3 restarts at col0/line0
        for (int p = 0; p < 3*LEN + 2; p++)
            step(1'b1, (p == 0), 1'b1, W'($urandom), 2'd3, "t6");
        last_px = W'($urandom);
        step(1'b1, 1'b1, 1'b1, last_px, 2'd3, "t6sof");
        chk("t6.rdy_drop", W'(oLINES_RDY), '0);
        step(1'b1, 1'b0, 1'b0, '0, 2'd3, "t6f");
        chk("t6.x0", oDATA, last_px);
        idle(1, "t6f");

        // reset mid-line, then first pixel is col0/line0
        step(1'b1, 1'b1, 1'b1, W'($urandom), 2'd2, "t1");
        step(1'b1, 1'b0, 1'b1, W'($urandom), 2'd2, "t1");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, W'($urandom), 2'd2, "t1rst");
        for (int p = 0; p < 2*LEN + 2; p++)
            step(1'b1, 1'b0, 1'b1, W'($urandom), 2'd3, "t1post");
        idle(2, "t1f");

        // random traffic
        for (int i = 0; i < 800; i++)
            step(($urandom % 150) != 0, ($urandom % 40) == 0,
                 ($urandom % 10) < 7, W'($urandom), 2'($urandom), "rnd");
        idle(3, "end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
